// File: rtl/led_sched_pkg.sv
// Shared types for the LED PWM channel scheduler: channel index, duty word
// and the scheduler state encoding.
package led_sched_pkg;

    localparam int NUM_CH_MAX = 8;
    localparam int CH_W       = $clog2(NUM_CH_MAX);
    localparam int DUTY_W_DEF = 16;

    typedef logic [CH_W-1:0]       ch_idx_t;
    typedef logic [DUTY_W_DEF-1:0] duty_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rr_next_channel.sv
// Round-robin search: first set bit of the mask strictly after the pointer,
// wrapping around, with the pointer itself considered last.
module rr_next_channel
    import led_sched_pkg::*;
#(
    parameter int NUM_CH = 3
)
(
    input  ch_idx_t           ptr_i,
    input  logic [NUM_CH-1:0] mask_i,
    output ch_idx_t           next_o,
    output logic              found_o
);

    // Scan from the farthest offset down to the nearest so the closest enabled channel wins.
    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (mask_i[(int'(ptr_i) + k) % NUM_CH]) begin
                next_o  = ch_idx_t'((int'(ptr_i) + k) % NUM_CH);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_channel_scheduler.sv
// Shares one PWM generator across NUM_CH LED channels: stores per-channel
// duties, rotates over enabled channels at period boundaries, loads the
// generator and steers its output bit into the active channel.
module pwm_channel_scheduler
    import led_sched_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int DUTY_W        = 16,
    parameter int DWELL_PERIODS = 1,
    parameter int HOLD_INACTIVE = 1,
    parameter int ACTIVE_LOW    = 1
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [$clog2(NUM_CH)-1:0] wr_ch_i,
    input  logic [DUTY_W-1:0]         wr_duty_i,
    input  logic [NUM_CH-1:0]         en_i,
    input  logic                      period_end_i,
    input  logic                      pwm_i,
    output logic                      update_o,
    output logic [DUTY_W-1:0]         duty_o,
    output logic [$clog2(NUM_CH)-1:0] active_ch_o,
    output logic                      active_vld_o,
    output logic                      wr_err_o,
    output logic [NUM_CH-1:0]         led_o
);

    localparam int AW = $clog2(NUM_CH);

    sched_state_e      state_q, state_d;
    logic [7:0]        dwell_q;
    logic [7:0]        dwell_inc;
    logic              boundary;
    logic [DUTY_W-1:0] duty_mem [NUM_CH];
    logic [AW-1:0]     active_ch_q;
    logic              active_vld_q;
    logic              update_q;
    logic [DUTY_W-1:0] duty_out_q;
    logic              err_q;
    logic [NUM_CH-1:0] ch_state_q;
    ch_idx_t           rr_next;
    logic              rr_found;
    logic [AW-1:0]     next_ch;
    logic              wr_accept;
    logic              unused_rr_bits;

    assign wr_ready_o     = !reset;
    assign wr_accept      = wr_valid_i && wr_ready_o;
    assign next_ch        = rr_next[AW-1:0];
    assign unused_rr_bits = ^rr_next;

    rr_next_channel #(
        .NUM_CH (NUM_CH)
    ) u_rr_next (
        .ptr_i   (ch_idx_t'(active_ch_q)),
        .mask_i  (en_i),
        .next_o  (rr_next),
        .found_o (rr_found)
    );

    // Scheduler state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and boundary detection; the first period end out of IDLE always rotates.
    always_comb begin
        state_d   = state_q;
        dwell_inc = dwell_q + 8'd1;
        boundary  = 1'b0;
        if (period_end_i) begin
            state_d  = RUN;
            boundary = (state_q == IDLE) || (dwell_inc >= 8'(DWELL_PERIODS));
        end
    end

    // Dwell counting, channel selection and the one-cycle generator load.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_q      <= '0;
            active_ch_q  <= AW'(NUM_CH - 1);
            active_vld_q <= 1'b0;
            update_q     <= 1'b0;
            duty_out_q   <= '0;
        end else begin
            update_q <= boundary;
            if (boundary) begin
                dwell_q <= '0;
                if (rr_found) begin
                    active_ch_q  <= next_ch;
                    active_vld_q <= 1'b1;
                    duty_out_q   <= duty_mem[next_ch];
                end else begin
                    active_vld_q <= 1'b0;
                    duty_out_q   <= '0;
                end
            end else if (period_end_i) begin
                dwell_q <= dwell_inc;
            end
        end
    end

    // Host duty writes; out-of-range channels are dropped and latch the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) duty_mem[i] <= '0;
            err_q <= 1'b0;
        end else if (wr_accept) begin
            if (int'(wr_ch_i) < NUM_CH) duty_mem[wr_ch_i] <= wr_duty_i;
            else                        err_q <= 1'b1;
        end
    end

    // Steer the generator bit into the active channel; a disabled active channel goes dark.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_state_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!active_vld_q)                ch_state_q[i] <= 1'b0;
                else if (i == int'(active_ch_q))  ch_state_q[i] <= en_i[i] ? pwm_i : 1'b0;
                else if (HOLD_INACTIVE == 0)      ch_state_q[i] <= 1'b0;
            end
        end
    end

    assign update_o     = update_q;
    assign duty_o       = duty_out_q;
    assign active_ch_o  = active_ch_q;
    assign active_vld_o = active_vld_q;
    assign wr_err_o     = err_q;
    assign led_o        = (ACTIVE_LOW != 0) ? ~ch_state_q : ch_state_q;

endmodule

// File: tb/tb_pwm_channel_scheduler.sv
// Directed bench for pwm_channel_scheduler. Instance a uses the default
// parameters (dwell 1, hold inactive); instance b uses dwell 3 and clears
// inactive channels. Both share every input.
module tb_pwm_channel_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [1:0]  wr_ch;
    logic [15:0] wr_duty;
    logic [2:0]  en;
    logic        period_end;
    logic        pwm;

    logic        a_ready, a_update, a_vld, a_err;
    logic [15:0] a_duty;
    logic [1:0]  a_ch;
    logic [2:0]  a_led;
    logic        b_ready, b_update, b_vld, b_err;
    logic [15:0] b_duty;
    logic [1:0]  b_ch;
    logic [2:0]  b_led;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_channel_scheduler #(
        .NUM_CH(3), .DUTY_W(16), .DWELL_PERIODS(1), .HOLD_INACTIVE(1), .ACTIVE_LOW(1)
    ) dut_a (
        .clk(clk), .reset(reset), .wr_valid_i(wr_valid), .wr_ready_o(a_ready),
        .wr_ch_i(wr_ch), .wr_duty_i(wr_duty), .en_i(en), .period_end_i(period_end),
        .pwm_i(pwm), .update_o(a_update), .duty_o(a_duty), .active_ch_o(a_ch),
        .active_vld_o(a_vld), .wr_err_o(a_err), .led_o(a_led)
    );

    pwm_channel_scheduler #(
        .NUM_CH(3), .DUTY_W(16), .DWELL_PERIODS(3), .HOLD_INACTIVE(0), .ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .reset(reset), .wr_valid_i(wr_valid), .wr_ready_o(b_ready),
        .wr_ch_i(wr_ch), .wr_duty_i(wr_duty), .en_i(en), .period_end_i(period_end),
        .pwm_i(pwm), .update_o(b_update), .duty_o(b_duty), .active_ch_o(b_ch),
        .active_vld_o(b_vld), .wr_err_o(b_err), .led_o(b_led)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_valid = 1'b0; wr_ch = '0; wr_duty = '0;
        en = 3'b111; period_end = 1'b0; pwm = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic write_duty(input logic [1:0] ch, input logic [15:0] d);
        wr_valid = 1'b1; wr_ch = ch; wr_duty = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_valid = 1'b0; wr_ch = '0; wr_duty = '0;
        en = 3'b111; period_end = 1'b0; pwm = 1'b1;
        tick(); tick();
        checks++; if (a_update !== 1'b0) begin errors++; $display("[TB] FAIL reset_update got %b exp 0", a_update); end
        checks++; if (a_duty !== 16'h0) begin errors++; $display("[TB] FAIL reset_duty got %h exp 0000", a_duty); end
        checks++; if (a_ch !== 2'd2) begin errors++; $display("[TB] FAIL reset_active_ch got %0d exp 2", a_ch); end
        checks++; if (a_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got %b exp 0", a_vld); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b exp 0", a_err); end
        checks++; if (a_led !== 3'b111) begin errors++; $display("[TB] FAIL reset_led got %b exp 111", a_led); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b exp 0", a_ready); end
        reset = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset got %b exp 1", a_ready); end
    endtask

    task automatic test_rotation();
        logic [1:0]  exp_ch   [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [15:0] exp_duty [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0100};
        do_reset();
        write_duty(2'd0, 16'h0100);
        write_duty(2'd1, 16'h0200);
        write_duty(2'd2, 16'h0300);
        for (int i = 0; i < 4; i++) begin
            repeat (9) tick();
            pulse();
            checks++; if (a_update !== 1'b1) begin errors++; $display("[TB] FAIL rot_update[%0d] got %b exp 1", i, a_update); end
            checks++; if (a_ch !== exp_ch[i]) begin errors++; $display("[TB] FAIL rot_ch[%0d] got %0d exp %0d", i, a_ch, exp_ch[i]); end
            checks++; if (a_duty !== exp_duty[i]) begin errors++; $display("[TB] FAIL rot_duty[%0d] got %h exp %h", i, a_duty, exp_duty[i]); end
            checks++; if (a_vld !== 1'b1) begin errors++; $display("[TB] FAIL rot_vld[%0d] got %b exp 1", i, a_vld); end
            tick();
            checks++; if (a_update !== 1'b0) begin errors++; $display("[TB] FAIL rot_strobe_len[%0d] got %b exp 0", i, a_update); end
            checks++; if (a_duty !== exp_duty[i]) begin errors++; $display("[TB] FAIL rot_duty_hold[%0d] got %h exp %h", i, a_duty, exp_duty[i]); end
        end
    endtask

    task automatic test_write_collision();
        do_reset();
        write_duty(2'd0, 16'h0AAA);
        write_duty(2'd1, 16'h0BBB);
        pulse();
        checks++; if (a_duty !== 16'h0AAA) begin errors++; $display("[TB] FAIL coll_first got %h exp 0aaa", a_duty); end
        period_end = 1'b1; wr_valid = 1'b1; wr_ch = 2'd1; wr_duty = 16'h1234;
        tick();
        period_end = 1'b0; wr_valid = 1'b0;
        checks++; if (a_ch !== 2'd1) begin errors++; $display("[TB] FAIL coll_ch got %0d exp 1", a_ch); end
        checks++; if (a_duty !== 16'h0BBB) begin errors++; $display("[TB] FAIL coll_old_duty got %h exp 0bbb", a_duty); end
        tick(); pulse();
        checks++; if (a_duty !== 16'h0000) begin errors++; $display("[TB] FAIL coll_ch2 got %h exp 0000", a_duty); end
        tick(); pulse();
        checks++; if (a_duty !== 16'h0AAA) begin errors++; $display("[TB] FAIL coll_ch0 got %h exp 0aaa", a_duty); end
        tick(); pulse();
        checks++; if (a_ch !== 2'd1 || a_duty !== 16'h1234) begin errors++; $display("[TB] FAIL coll_new_duty got ch%0d %h exp ch1 1234", a_ch, a_duty); end
    endtask

    task automatic test_mask();
        logic [1:0] exp_ch [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
        do_reset();
        en = 3'b101; pwm = 1'b1;
        write_duty(2'd0, 16'h0011);
        write_duty(2'd2, 16'h0022);
        for (int i = 0; i < 4; i++) begin
            pulse();
            checks++; if (a_ch !== exp_ch[i]) begin errors++; $display("[TB] FAIL mask_ch[%0d] got %0d exp %0d", i, a_ch, exp_ch[i]); end
            tick(); tick();
        end
        checks++; if (a_led !== 3'b010) begin errors++; $display("[TB] FAIL mask_hold_led got %b exp 010", a_led); end
        en = 3'b000;
        tick();
        checks++; if (a_led !== 3'b110) begin errors++; $display("[TB] FAIL mask_disable_active got %b exp 110", a_led); end
        pulse();
        checks++; if (a_update !== 1'b1 || a_vld !== 1'b0) begin errors++; $display("[TB] FAIL none_strobe got upd%b vld%b exp upd1 vld0", a_update, a_vld); end
        checks++; if (a_duty !== 16'h0000 || a_ch !== 2'd2) begin errors++; $display("[TB] FAIL none_duty got %h ch%0d exp 0000 ch2", a_duty, a_ch); end
        tick();
        checks++; if (a_led !== 3'b111) begin errors++; $display("[TB] FAIL none_led got %b exp 111", a_led); end
    endtask

    task automatic test_dwell();
        logic       exp_upd [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] exp_ch  [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            pulse();
            checks++; if (b_update !== exp_upd[i] || b_ch !== exp_ch[i]) begin errors++; $display("[TB] FAIL dwell[%0d] got upd%b ch%0d exp upd%b ch%0d", i, b_update, b_ch, exp_upd[i], exp_ch[i]); end
            repeat (3) tick();
        end
    endtask

    task automatic test_write_error();
        do_reset();
        write_duty(2'd1, 16'h5555);
        checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clean got %b exp 0", a_err); end
        write_duty(2'd3, 16'hFFFF);
        checks++; if (a_err !== 1'b1) begin errors++; $display("[TB] FAIL err_set got %b exp 1", a_err); end
        repeat (4) tick();
        pulse();
        checks++; if (a_duty !== 16'h0000) begin errors++; $display("[TB] FAIL err_ch0 got %h exp 0000", a_duty); end
        pulse();
        checks++; if (a_duty !== 16'h5555) begin errors++; $display("[TB] FAIL err_ch1 got %h exp 5555", a_duty); end
        pulse();
        checks++; if (a_duty !== 16'h0000) begin errors++; $display("[TB] FAIL err_ch2 got %h exp 0000", a_duty); end
        checks++; if (a_err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got %b exp 1", a_err); end
        do_reset();
        checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared got %b exp 0", a_err); end
    endtask

    task automatic test_steering();
        logic [7:0] pattern = 8'b1011_0010;
        do_reset();
        pulse();
        for (int i = 0; i < 8; i++) begin
            pwm = pattern[i];
            tick();
            checks++; if (b_led !== {2'b11, ~pattern[i]}) begin errors++; $display("[TB] FAIL steer[%0d] got %b exp %b", i, b_led, {2'b11, ~pattern[i]}); end
        end
        pwm = 1'b1;
        tick();
        pulse(); tick(); pulse(); tick(); pulse();
        checks++; if (b_ch !== 2'd1) begin errors++; $display("[TB] FAIL steer_adv got %0d exp 1", b_ch); end
        tick();
        checks++; if (b_led !== 3'b101) begin errors++; $display("[TB] FAIL steer_clear_inactive got %b exp 101", b_led); end
        checks++; if (a_ch !== 2'd0 || a_led !== 3'b000) begin errors++; $display("[TB] FAIL steer_hold_a got ch%0d %b exp ch0 000", a_ch, a_led); end
        reset = 1'b1;
        tick();
        checks++; if (a_led !== 3'b111 || b_led !== 3'b111) begin errors++; $display("[TB] FAIL midrun_reset_led got %b %b exp 111 111", a_led, b_led); end
        reset = 1'b0;
        tick();
        pulse();
        checks++; if (a_ch !== 2'd0 || a_update !== 1'b1) begin errors++; $display("[TB] FAIL midrun_first_a got ch%0d upd%b exp ch0 upd1", a_ch, a_update); end
        checks++; if (b_ch !== 2'd0 || b_update !== 1'b1) begin errors++; $display("[TB] FAIL midrun_first_b got ch%0d upd%b exp ch0 upd1", b_ch, b_update); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_rotation();
        test_write_collision();
        test_mask();
        test_dwell();
        test_write_error();
        test_steering();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
